seqdet_stream_ctrl: RTL and testbench

Streaming controller for the serial sequence detector core (seqdet_clean: in_i, clock_i, areset_ni, out_o). It accepts parallel words over a valid/ready handshake and serializes them into the detector one bit per clock. It also owns the detector's reset and collects hit events into a counter, a hit-position record and a threshold interrupt. It sits between the bus-side word source and the detector instance.

---
 rtl/seqdet_stream_ctrl.sv | 168 ++++++++++++++++
 tb/tb_seqdet_stream_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seqdet_stream_ctrl.sv
// Serializes valid/ready words into the sequence detector one bit per clock,
// owns the detector reset and records hit count, position and a sticky threshold irq.
module seqdet_stream_ctrl #(
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                      clock_i,
    input  logic                      areset_ni,
    input  logic                      enable_i,
    input  logic [WORD_W-1:0]         word_i,
    input  logic                      word_valid_i,
    output logic                      word_ready_o,
    output logic                      det_bit_o,
    output logic                      det_rst_no,
    input  logic                      det_hit_i,
    input  logic                      clear_i,
    input  logic [CNT_W-1:0]          thresh_i,
    output logic                      hit_valid_o,
    output logic [CNT_W-1:0]          hit_count_o,
    output logic [CNT_W-1:0]          hit_word_o,
    output logic [$clog2(WORD_W)-1:0] hit_bit_o,
    output logic                      irq_o,
    output logic                      busy_o
);

    localparam int BIT_W = $clog2(WORD_W);
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(WORD_W - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [WORD_W-1:0]   r_shift;
    logic [BIT_W-1:0]    r_bit_idx;
    logic                r_det_bit;
    logic                r_det_rst_n;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [CNT_W-1:0]    r_cur_idx;
    logic [CNT_W-1:0]    r_hit_cnt;
    logic [CNT_W-1:0]    r_hit_word;
    logic [BIT_W-1:0]    r_hit_bit;
    logic                r_hit_vld;
    logic                r_irq;

    logic                w_last;
    logic                w_busy;
    logic                w_ready;
    logic                w_accept;
    logic                w_hit;
    logic                w_first_bit;
    logic                w_next_bit;
    logic [WORD_W-1:0]   w_load_rest;
    logic [WORD_W-1:0]   w_shift_rest;

    assign w_last   = (r_bit_idx == LAST_IDX);
    assign w_accept = word_valid_i && w_ready;
    assign w_hit    = w_busy && det_hit_i;

    // The register always holds the not-yet-driven bits aligned to the serial end.
    if (MSB_FIRST) begin : g_msb_first
        assign w_first_bit  = word_i[WORD_W-1];
        assign w_load_rest  = word_i << 1;
        assign w_next_bit   = r_shift[WORD_W-1];
        assign w_shift_rest = r_shift << 1;
    end else begin : g_lsb_first
        assign w_first_bit  = word_i[0];
        assign w_load_rest  = word_i >> 1;
        assign w_next_bit   = r_shift[0];
        assign w_shift_rest = r_shift >> 1;
    end

    always_ff @(posedge clock_i or negedge areset_ni) begin
        if (!areset_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)            w_next_state = S_SHIFT;
            S_SHIFT: if (w_last && !w_accept) w_next_state = S_IDLE;
            default:                          w_next_state = S_IDLE;
        endcase
    end

    // Ready is masked during reset so nothing can be taken while the state is forced.
    always_comb begin
        w_busy  = (r_state == S_SHIFT);
        w_ready = areset_ni && enable_i && ((r_state == S_IDLE) || w_last);
    end

    always_ff @(posedge clock_i or negedge areset_ni) begin
        if (!areset_ni) begin
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_det_bit   <= 1'b0;
            r_det_rst_n <= 1'b0;
            r_cur_idx   <= '0;
        end else begin
            if (w_accept) begin
                r_shift   <= w_load_rest;
                r_det_bit <= w_first_bit;
                r_bit_idx <= '0;
                r_cur_idx <= r_word_cnt;
            end else if (w_busy && !w_last) begin
                r_shift   <= w_shift_rest;
                r_det_bit <= w_next_bit;
                r_bit_idx <= r_bit_idx + BIT_W'(1);
            end else if (w_busy) begin
                r_det_bit <= 1'b0;
                r_bit_idx <= '0;
            end
            r_det_rst_n <= (w_next_state == S_SHIFT);
        end
    end

    // Clear has priority over a same-cycle hit, which is then dropped.
    always_ff @(posedge clock_i or negedge areset_ni) begin
        if (!areset_ni) begin
            r_word_cnt <= '0;
            r_hit_cnt  <= '0;
            r_hit_word <= '0;
            r_hit_bit  <= '0;
            r_hit_vld  <= 1'b0;
            r_irq      <= 1'b0;
        end else if (clear_i) begin
            r_word_cnt <= '0;
            r_hit_cnt  <= '0;
            r_hit_word <= '0;
            r_hit_bit  <= '0;
            r_hit_vld  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_hit_vld <= w_hit;
            if (w_accept) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            if (w_hit) begin
                if (r_hit_cnt != '1) begin
                    r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                end
                r_hit_word <= r_cur_idx;
                r_hit_bit  <= r_bit_idx;
            end
            if ((thresh_i != '0) && (r_hit_cnt >= thresh_i)) begin
                r_irq <= 1'b1;
            end
        end
    end

    assign word_ready_o = w_ready;
    assign busy_o       = w_busy;
    assign det_bit_o    = r_det_bit;
    assign det_rst_no   = r_det_rst_n;
    assign hit_valid_o  = r_hit_vld;
    assign hit_count_o  = r_hit_cnt;
    assign hit_word_o   = r_hit_word;
    assign hit_bit_o    = r_hit_bit;
    assign irq_o        = r_irq;

endmodule

// File: tb/tb_seqdet_stream_ctrl.sv
// Bench for seqdet_stream_ctrl: two instances (16-bit and 2-bit counters) driven
// by directed and random traffic, each feeding a 1011 detector stub.
module tb_seqdet_stream_ctrl;

    localparam int W = 8;

    logic        clock_i;
    logic        areset_ni;
    logic        enable_i;
    logic [W-1:0] word_i;
    logic        word_valid_i;
    logic        clear_i;
    logic [15:0] thresh_i;
    logic        inj_hit;

    logic        word_ready_o, det_bit_o, det_rst_no, det_hit_i;
    logic        hit_valid_o, irq_o, busy_o;
    logic [15:0] hit_count_o, hit_word_o;
    logic [2:0]  hit_bit_o;

    logic        s_ready, s_det_bit, s_det_rst_n, s_det_hit;
    logic        s_hit_valid, s_irq, s_busy;
    logic [1:0]  s_hit_count, s_hit_word;
    logic [2:0]  s_hit_bit;

    logic [2:0]  stub_a, stub_b;

    seqdet_stream_ctrl #(.WORD_W(W), .CNT_W(16), .MSB_FIRST(1'b1)) u_dut (
        .clock_i(clock_i), .areset_ni(areset_ni), .enable_i(enable_i),
        .word_i(word_i), .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
        .det_bit_o(det_bit_o), .det_rst_no(det_rst_no), .det_hit_i(det_hit_i),
        .clear_i(clear_i), .thresh_i(thresh_i), .hit_valid_o(hit_valid_o),
        .hit_count_o(hit_count_o), .hit_word_o(hit_word_o), .hit_bit_o(hit_bit_o),
        .irq_o(irq_o), .busy_o(busy_o)
    );

    seqdet_stream_ctrl #(.WORD_W(W), .CNT_W(2), .MSB_FIRST(1'b1)) u_sat (
        .clock_i(clock_i), .areset_ni(areset_ni), .enable_i(enable_i),
        .word_i(word_i), .word_valid_i(word_valid_i), .word_ready_o(s_ready),
        .det_bit_o(s_det_bit), .det_rst_no(s_det_rst_n), .det_hit_i(s_det_hit),
        .clear_i(clear_i), .thresh_i(thresh_i[1:0]), .hit_valid_o(s_hit_valid),
        .hit_count_o(s_hit_count), .hit_word_o(s_hit_word), .hit_bit_o(s_hit_bit),
        .irq_o(s_irq), .busy_o(s_busy)
    );

    // Detector stubs: flag when the last three bits plus the current bit read 1011.
    always_ff @(posedge clock_i or negedge det_rst_no) begin
        if (!det_rst_no) stub_a <= '0;
        else             stub_a <= {stub_a[1:0], det_bit_o};
    end
    always_ff @(posedge clock_i or negedge s_det_rst_n) begin
        if (!s_det_rst_n) stub_b <= '0;
        else              stub_b <= {stub_b[1:0], s_det_bit};
    end
    assign det_hit_i = inj_hit || (det_rst_no  && ({stub_a, det_bit_o} == 4'b1011));
    assign s_det_hit = inj_hit || (s_det_rst_n && ({stub_b, s_det_bit} == 4'b1011));

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    // Reference model: queue of pending serial bits tagged with word index and position.
    typedef struct {
        logic b;
        int   idx;
        int   pos;
    } mbit_t;

    mbit_t mq[$];
    bit    hist[$];
    int    m_cnt, m_sat, m_wcnt, m_hw, m_hb, m_hv, m_irq;
    bit    m_acc;
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        mq.delete();
        hist.delete();
        m_cnt = 0; m_sat = 0; m_wcnt = 0; m_hw = 0; m_hb = 0; m_hv = 0; m_irq = 0;
        m_acc = 1'b0;
    endtask

    task automatic tick();
        bit busy, hit, rdy, pat;
        logic [W-1:0] wb;
        @(negedge clock_i);
        busy = (mq.size() != 0);
        rdy  = areset_ni && enable_i && (mq.size() <= 1);
        chk("ready",    word_ready_o, rdy);
        chk("busy",     busy_o,       busy);
        chk("det_rst",  det_rst_no,   busy);
        chk("det_bit",  det_bit_o,    busy ? mq[0].b : 1'b0);
        chk("hit_vld",  hit_valid_o,  m_hv);
        chk("hit_cnt",  hit_count_o,  m_cnt);
        chk("hit_word", hit_word_o,   m_hw);
        chk("hit_bit",  hit_bit_o,    m_hb);
        chk("irq",      irq_o,        m_irq);
        chk("sat_cnt",  s_hit_count,  m_sat);

        pat = busy && (hist.size() >= 3) && hist[hist.size()-3] && !hist[hist.size()-2]
              && hist[hist.size()-1] && mq[0].b;
        hit = busy && (inj_hit || pat);
        m_acc = word_valid_i && rdy;
        wb = word_i;

        m_irq = clear_i ? 0 : ((m_irq != 0) || (thresh_i != 0 && m_cnt >= thresh_i));
        if (clear_i) begin
            m_cnt = 0; m_sat = 0; m_hw = 0; m_hb = 0; m_hv = 0;
        end else begin
            m_hv = hit;
            if (hit) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_sat < 3)     m_sat++;
                m_hw = mq[0].idx;
                m_hb = mq[0].pos;
            end
        end
        if (busy) begin
            hist.push_back(mq[0].b);
            if (hist.size() > 3) hist.delete(0);
            mq.delete(0);
        end
        if (m_acc) begin
            for (int i = 0; i < W; i++) mq.push_back('{b: wb[W-1-i], idx: m_wcnt, pos: i});
        end
        m_wcnt = clear_i ? 0 : (m_acc ? (m_wcnt + 1) % 65536 : m_wcnt);
        if (mq.size() == 0) hist.delete();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drive_word(input logic [W-1:0] w, input int gap);
        int t;
        word_i = w;
        word_valid_i = 1'b1;
        t = 0;
        do begin
            tick();
            t++;
        end while (!m_acc && t < 50);
        chk("accept", m_acc, 1'b1);
        word_valid_i = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, word_ready_o, 1'b0);
        chk({tag, "_busy"},  busy_o,       1'b0);
        chk({tag, "_rst"},   det_rst_no,   1'b0);
        chk({tag, "_bit"},   det_bit_o,    1'b0);
        chk({tag, "_cnt"},   hit_count_o,  16'd0);
        chk({tag, "_hw"},    hit_word_o,   16'd0);
        chk({tag, "_hb"},    hit_bit_o,    3'd0);
        chk({tag, "_irq"},   irq_o,        1'b0);
        chk({tag, "_hv"},    hit_valid_o,  1'b0);
    endtask

    initial begin
        areset_ni = 1'b1; enable_i = 1'b1; word_i = '0; word_valid_i = 1'b0;
        clear_i = 1'b0; thresh_i = '0; inj_hit = 1'b0;
        reset_model();
        #2 areset_ni = 1'b0;
        #1 check_all_zero("rst");
        repeat (2) @(posedge clock_i);
        #1 areset_ni = 1'b1;

        // Single word: one hit at serial position 3.
        drive_word(8'hB0, 12);
        chk("single_cnt", hit_count_o, 16'd1);
        chk("single_bit", hit_bit_o, 3'd3);
        chk("single_word", hit_word_o, 16'd0);
        chk("single_idle_rst", det_rst_no, 1'b0);

        // Back-to-back words: match spans the word boundary.
        pulse_clear();
        drive_word(8'h05, 0);
        drive_word(8'h80, 12);
        chk("b2b_cnt", hit_count_o, 16'd1);
        chk("b2b_word", hit_word_o, 16'd1);
        chk("b2b_bit", hit_bit_o, 3'd0);

        // Same words with an underrun gap: detector is reset, no hit.
        pulse_clear();
        drive_word(8'h05, 8);
        drive_word(8'h80, 12);
        chk("gap_cnt", hit_count_o, 16'd0);

        // Overlapping hits inside one word.
        pulse_clear();
        drive_word(8'hB6, 12);
        chk("ovl_cnt", hit_count_o, 16'd2);
        chk("ovl_bit", hit_bit_o, 3'd6);

        // Threshold interrupt.
        pulse_clear();
        thresh_i = 16'd3;
        drive_word(8'hB6, 0);
        drive_word(8'hB0, 12);
        chk("irq_cnt", hit_count_o, 16'd3);
        chk("irq_set", irq_o, 1'b1);
        thresh_i = 16'd9;
        tick();
        chk("irq_sticky", irq_o, 1'b1);

        // Clear in the hit cycle drops that hit.
        word_i = 8'hB0; word_valid_i = 1'b1;
        tick();
        word_valid_i = 1'b0;
        repeat (3) tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_cnt", hit_count_o, 16'd0);
        chk("clr_irq", irq_o, 1'b0);
        chk("clr_hv", hit_valid_o, 1'b0);
        repeat (8) tick();

        // Saturation of the 2-bit counter.
        thresh_i = 16'd0;
        pulse_clear();
        drive_word(8'hB6, 0);
        drive_word(8'hB6, 0);
        drive_word(8'hB6, 12);
        chk("sat_small", s_hit_count, 2'd3);
        chk("sat_big", hit_count_o, 16'd6);

        // Asynchronous reset at bit 4 of a word.
        pulse_clear();
        drive_word(8'hB6, 0);
        repeat (4) tick();
        areset_ni = 1'b0;
        #1 check_all_zero("mid_rst");
        reset_model();
        @(posedge clock_i);
        #1 areset_ni = 1'b1;
        drive_word(8'hB0, 12);
        chk("post_rst_cnt", hit_count_o, 16'd1);
        chk("post_rst_bit", hit_bit_o, 3'd3);
        chk("post_rst_word", hit_word_o, 16'd0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            enable_i     = ($urandom % 8) != 0;
            word_valid_i = ($urandom % 3) != 0;
            word_i       = W'($urandom);
            clear_i      = ($urandom % 60) == 0;
            inj_hit      = ($urandom % 10) == 0;
            if (($urandom % 80) == 0) thresh_i = 16'($urandom_range(0, 6));
            tick();
        end
        inj_hit = 1'b0; clear_i = 1'b0; word_valid_i = 1'b0;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
